// File: rtl/pcileech_rx_parser.sv
// pcileech_rx_parser
//
// Splits the FT601 receive word stream into qwords. The first word of a
// qword is the payload and the second is the header. A header whose magic
// matches MAGIC sends the payload to one of three outputs, chosen by the
// header type field:
//   type 00 -> TLP word stream
//   type 01 -> config write stream
//   type 10 -> loopback qword for the TX path
//   type 11 -> dropped
// A header with the wrong magic resynchronises the stream. The word that
// failed becomes the new payload, so the parser slides forward one word.
// If a payload waits too long for its header, it is discarded.
//
// Header word layout:
//   [31:24] magic, [23:20] reserved, [19] tlp last, [18] ignored,
//   [17:16] type, [15:0] config address
//
// Parameters:
//   MAGIC          - required value of header bits [31:24]
//   TIMEOUT_CYCLES - idle cycles a held payload may wait for its header
//                    (must be at least 1)
//
// Ports:
//   clk, rst      - rising-edge clock and synchronous active-high reset
//   rx_data       - receive word
//   rx_wr         - rx_data is valid this cycle (no backpressure)
//   tlp_data/tlp_last/tlp_valid   - TLP word stream
//   cfg_data/cfg_addr/cfg_valid   - config write stream
//   loop_data/loop_valid          - loopback qword {header, payload}
//   bad_magic_cnt, timeout_cnt    - saturating error statistics
//   fsm_state     - debug view of the FSM: 0 = S_W0 (empty),
//                   1 = S_W1 (payload held)
//
// Build option: when PCILEECH_RX_PARSER_STATS_EN is defined, the two
// statistic counters are built. When it is not defined, both counter ports
// read 16'h0000.
//
// Valid semantics: every *_valid is a registered one-cycle strobe with no
// ready signal. The matching data outputs are meaningful only while it is
// high, and they hold their last value otherwise.

module pcileech_rx_parser #(
    parameter logic [7:0] MAGIC          = 8'h77,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_data,
    input  logic        rx_wr,
    output logic [31:0] tlp_data,
    output logic        tlp_last,
    output logic        tlp_valid,
    output logic [31:0] cfg_data,
    output logic [15:0] cfg_addr,
    output logic        cfg_valid,
    output logic [63:0] loop_data,
    output logic        loop_valid,
    output logic [15:0] bad_magic_cnt,
    output logic [15:0] timeout_cnt,
    output logic        fsm_state
);

    typedef enum logic {
        S_W0 = 1'b0,
        S_W1 = 1'b1
    } state_t;

    // Value of idle_cnt on the cycle that completes TIMEOUT_CYCLES idle cycles.
    localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [31:0] payload;
    logic [31:0] idle_cnt;
    logic        hdr_ok;
    logic        dispatch;
    logic        timeout_hit;

    assign hdr_ok   = (rx_data[31:24] == MAGIC);
    assign dispatch = (state == S_W1) && rx_wr && hdr_ok;
    // rx_wr takes priority: a word that arrives on the expiry cycle is
    // still used as the header.
    assign timeout_hit = (state == S_W1) && !rx_wr && (idle_cnt == TLIM);
    assign fsm_state   = state;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_W0;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_W0: begin
                if (rx_wr) begin
                    state_next = S_W1;
                end
            end
            S_W1: begin
                if (rx_wr) begin
                    // A bad magic keeps the FSM in S_W1 with a new payload.
                    if (hdr_ok) begin
                        state_next = S_W0;
                    end
                end else if (timeout_hit) begin
                    state_next = S_W0;
                end
            end
            default: state_next = S_W0;
        endcase
    end

    // Payload holding register, idle counter and registered dispatch
    always_ff @(posedge clk) begin
        if (rst) begin
            payload    <= '0;
            idle_cnt   <= '0;
            tlp_data   <= '0;
            tlp_last   <= 1'b0;
            tlp_valid  <= 1'b0;
            cfg_data   <= '0;
            cfg_addr   <= '0;
            cfg_valid  <= 1'b0;
            loop_data  <= '0;
            loop_valid <= 1'b0;
        end else begin
            tlp_valid  <= 1'b0;
            cfg_valid  <= 1'b0;
            loop_valid <= 1'b0;

            // Latch a payload on entry to S_W1, whether from S_W0 or by
            // sliding past a bad header. The idle count restarts at zero.
            if (rx_wr && ((state == S_W0) || !hdr_ok)) begin
                payload  <= rx_data;
                idle_cnt <= '0;
            end else if ((state == S_W1) && !rx_wr) begin
                idle_cnt <= idle_cnt + 32'd1;
            end

            if (dispatch) begin
                case (rx_data[17:16])
                    2'b00: begin
                        tlp_valid <= 1'b1;
                        tlp_data  <= payload;
                        tlp_last  <= rx_data[19];
                    end
                    2'b01: begin
                        cfg_valid <= 1'b1;
                        cfg_data  <= payload;
                        cfg_addr  <= rx_data[15:0];
                    end
                    2'b10: begin
                        loop_valid <= 1'b1;
                        loop_data  <= {rx_data, payload};
                    end
                    default: ; // type 11 is dropped
                endcase
            end
        end
    end

`ifdef PCILEECH_RX_PARSER_STATS_EN
    logic        bad_magic;
    logic [15:0] bad_q;
    logic [15:0] tmo_q;

    assign bad_magic = (state == S_W1) && rx_wr && !hdr_ok;

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_q <= '0;
            tmo_q <= '0;
        end else begin
            if (bad_magic && (bad_q != 16'hFFFF)) begin
                bad_q <= bad_q + 16'd1;
            end
            if (timeout_hit && (tmo_q != 16'hFFFF)) begin
                tmo_q <= tmo_q + 16'd1;
            end
        end
    end

    assign bad_magic_cnt = bad_q;
    assign timeout_cnt   = tmo_q;
`else
    assign bad_magic_cnt = 16'h0000;
    assign timeout_cnt   = 16'h0000;
`endif

endmodule
